dsp_systolic_27x27s: RTL and testbench

DSP_SYSTOLIC_27X27S -- requirements
Module: dsp_systolic_27x27s

---
 rtl/dsp_systolic_27x27s.sv | 49 ++++
 tb/tb_dsp_systolic_27x27s.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dsp_systolic_27x27s.sv
// dsp_systolic_27x27s: NUM signed multipliers summed along a systolic register chain, then PIPELINE-1 output registers.
// Defining DSP_SYSTOLIC_27X27S_ENA_EN adds a clock-enable input ena; reset overrides it.
module dsp_systolic_27x27s #(
    parameter FAMILY = "Agilex",
    parameter int PIPELINE = 3,
    parameter int AX_WIDTH = 27,
    parameter int AY_WIDTH = 27,
    parameter int NUM = 10,
    parameter int RESULT_A_WIDTH = 64
) (
    input logic clk,
    input logic reset,
`ifdef DSP_SYSTOLIC_27X27S_ENA_EN
    input logic ena,
`endif
    input logic signed [AX_WIDTH-1:0] ax [0:NUM-1],
    input logic signed [AY_WIDTH-1:0] ay [0:NUM-1],
    output logic signed [RESULT_A_WIDTH-1:0] result
);
    localparam int PW = AX_WIDTH + AY_WIDTH;
    localparam int EW = RESULT_A_WIDTH > PW ? RESULT_A_WIDTH : PW;
    localparam int TOT = NUM + PIPELINE - 1;
    logic en;
    logic signed [EW-1:0] full [NUM];
    logic signed [RESULT_A_WIDTH-1:0] st [TOT];
`ifdef DSP_SYSTOLIC_27X27S_ENA_EN
    assign en = ena;
`else
    assign en = 1'b1;
`endif
    if (PIPELINE < 1 || PIPELINE > 4 || NUM < 1 || NUM > 16) begin : g_bad_cfg
        $error("%s: PIPELINE or NUM out of range", FAMILY);
    end
    // Products are formed at a width holding both the exact product and the result, then wrapped to the result width.
    always_comb begin
        for (int i = 0; i < NUM; i++) full[i] = EW'(ax[i]) * EW'(ay[i]);
    end
    // st[0..NUM-1] is the adder chain, the remaining entries are plain output delay registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TOT; i++) st[i] <= '0;
        end else if (en) begin
            st[0] <= full[0][RESULT_A_WIDTH-1:0];
            for (int i = 1; i < NUM; i++) st[i] <= full[i][RESULT_A_WIDTH-1:0] + st[i-1];
            for (int i = NUM; i < TOT; i++) st[i] <= st[i-1];
        end
    end
    assign result = st[TOT-1];
endmodule

// File: tb/tb_dsp_systolic_27x27s.sv
// tb_dsp_systolic_27x27s: randomized and directed checks of dsp_systolic_27x27s against a history-based sum model.
module tb_dsp_systolic_27x27s;
    localparam int N = 10;
    localparam int P = 3;
    localparam int MAXT = 2048;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [26:0] ax [0:N-1];
    logic signed [26:0] ay [0:N-1];
    logic signed [63:0] result;
    longint prod_h [MAXT][N];
    bit rst_h [MAXT];
    int t = 0;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    dsp_systolic_27x27s #(.FAMILY("Agilex"), .PIPELINE(P), .AX_WIDTH(27), .AY_WIDTH(27),
        .NUM(N), .RESULT_A_WIDTH(64)) dut (
        .clk(clk),
        .reset(reset),
`ifdef DSP_SYSTOLIC_27X27S_ENA_EN
        .ena(1'b1),
`endif
        .ax(ax),
        .ay(ay),
        .result(result)
    );
    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", tag, t, got, exp);
        end
    endtask
    // Sum of every lane product whose sampling edge lies exactly at its lane latency before edge e, unless a reset edge intervened.
    function automatic longint model(input int e);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            int src = e - (P - 1) - (N - 1 - i);
            bit ok = src >= 0;
            for (int k = (src < 0 ? 0 : src); ok && k <= e; k++) if (rst_h[k]) ok = 0;
            if (ok) s += prod_h[src][i];
        end
        return s;
    endfunction
    task automatic tick(input string tag);
        @(posedge clk);
        for (int i = 0; i < N; i++) prod_h[t][i] = longint'(ax[i]) * longint'(ay[i]);
        rst_h[t] = reset;
        #1;
        check(tag, result, model(t));
        t++;
    endtask
    task automatic zero_in();
        for (int i = 0; i < N; i++) begin
            ax[i] = '0;
            ay[i] = '0;
        end
    endtask
    task automatic rand_in();
        for (int i = 0; i < N; i++) begin
            int unsigned r = $urandom_range(0, 9);
            ax[i] = r == 0 ? -27'sd67108864 : r == 1 ? 27'sd67108863 : 27'($urandom);
            ay[i] = r == 2 ? -27'sd67108864 : r == 3 ? 27'sd67108863 : 27'($urandom);
        end
    endtask
    initial begin
        rand_in();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick("reset_model");
            check("reset_zero", result, 64'sd0);
            rand_in();
        end
        reset = 1'b0;
        zero_in();
        for (int k = 0; k < 12; k++) begin
            tick("idle_model");
            check("idle_zero", result, 64'sd0);
        end
        ax[9] = 27'sd3;
        ay[9] = 27'sd5;
        for (int k = 0; k < 14; k++) begin
            tick("last_lane_model");
            check("last_lane", result, k == 2 ? 64'sd15 : 64'sd0);
            zero_in();
        end
        ax[0] = -27'sd2;
        ay[0] = 27'sd7;
        for (int k = 0; k < 15; k++) begin
            tick("first_lane_model");
            check("first_lane", result, k == 11 ? -64'sd14 : 64'sd0);
            zero_in();
        end
        for (int i = 0; i < N; i++) begin
            ax[i] = -27'sd67108864;
            ay[i] = -27'sd67108864;
        end
        for (int k = 0; k < 16; k++) begin
            tick("min_min_model");
            if (k >= 12) check("min_min", result, 64'sd45035996273704960);
        end
        for (int i = 0; i < N; i++) ay[i] = 27'sd67108863;
        for (int k = 0; k < 16; k++) begin
            tick("min_max_model");
            if (k >= 12) check("min_max", result, -64'sd10 * ((64'sd1 <<< 52) - (64'sd1 <<< 26)));
        end
        for (int k = 0; k < 1000; k++) begin
            rand_in();
            tick("random");
        end
        for (int k = 0; k < 40; k++) begin
            rand_in();
            tick("pre_reset");
        end
        reset = 1'b1;
        rand_in();
        tick("mid_reset_model");
        check("mid_reset", result, 64'sd0);
        reset = 1'b0;
        zero_in();
        for (int k = 0; k < 13; k++) begin
            tick("post_reset_model");
            check("post_reset_zero", result, 64'sd0);
        end
        for (int k = 0; k < 40; k++) begin
            rand_in();
            tick("post_reset_random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
